// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter that lets the icache and dcache Wishbone
// masters share one L2 slave port. The granted master's bus is passed straight
// through and ack is returned combinationally. One idle cycle follows every
// transfer, whether it completed or was aborted.
// Optional build macro WB_ARBITER_STATS_EN adds the grant and conflict counters.
// Without the macro, stat_* are tied to zero and no counter flops exist.
module wb_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned SEL_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // icache side
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_adr,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [DATA_W-1:0] i_dat_m,
  output logic [DATA_W-1:0] i_dat_s,
  output logic              i_ack,
  // dcache side
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [SEL_W-1:0]  d_sel,
  input  logic [DATA_W-1:0] d_dat_m,
  output logic [DATA_W-1:0] d_dat_s,
  output logic              d_ack,
  // L2 side
  output logic              l2_cyc,
  output logic              l2_stb,
  output logic              l2_we,
  output logic [ADDR_W-1:0] l2_adr,
  output logic [SEL_W-1:0]  l2_sel,
  output logic [DATA_W-1:0] l2_dat_m,
  input  logic [DATA_W-1:0] l2_dat_s,
  input  logic              l2_ack,
  // statistics
  output logic [31:0]       stat_i_grants,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_conflicts
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  // last_grant encoding: 0 = icache, 1 = dcache
  localparam logic LG_I = 1'b0;
  localparam logic LG_D = 1'b1;

  state_t state, state_nx;
  logic   last_grant, last_grant_nx;
  logic   i_req, d_req;

  assign i_req = i_cyc & i_stb;
  assign d_req = d_cyc & d_stb;

  // Read data fans out to both masters; only the granted one sees ack.
  assign i_dat_s = l2_dat_s;
  assign d_dat_s = l2_dat_s;

  // State and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= LG_I;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
    end
  end

  // Next-state, grant selection and L2 bus steering
  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    l2_cyc        = 1'b0;
    l2_stb        = 1'b0;
    l2_we         = 1'b0;
    l2_adr        = '0;
    l2_sel        = '0;
    l2_dat_m      = '0;
    i_ack         = 1'b0;
    d_ack         = 1'b0;
    unique case (state)
      IDLE: begin
        // On contention, grant the master that did not win last time.
        if (i_req && d_req) begin
          if (last_grant == LG_I) begin
            state_nx      = GNT_D;
            last_grant_nx = LG_D;
          end else begin
            state_nx      = GNT_I;
            last_grant_nx = LG_I;
          end
        end else if (i_req) begin
          state_nx      = GNT_I;
          last_grant_nx = LG_I;
        end else if (d_req) begin
          state_nx      = GNT_D;
          last_grant_nx = LG_D;
        end
      end
      GNT_I: begin
        l2_cyc   = i_cyc;
        l2_stb   = i_stb;
        l2_we    = i_we;
        l2_adr   = i_adr;
        l2_sel   = i_sel;
        l2_dat_m = i_dat_m;
        i_ack    = l2_ack;
        // A dropped cyc (abort) or a completed transfer both end the grant.
        if (!i_cyc || l2_ack) state_nx = IDLE;
      end
      GNT_D: begin
        l2_cyc   = d_cyc;
        l2_stb   = d_stb;
        l2_we    = d_we;
        l2_adr   = d_adr;
        l2_sel   = d_sel;
        l2_dat_m = d_dat_m;
        d_ack    = l2_ack;
        if (!d_cyc || l2_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef WB_ARBITER_STATS_EN
  logic i_done, d_done, conflict;

  // An acked transfer counts only while the master still holds cyc.
  assign i_done   = (state == GNT_I) && i_cyc && l2_ack;
  assign d_done   = (state == GNT_D) && d_cyc && l2_ack;
  assign conflict = (state == IDLE) && i_req && d_req;

  // Free-running, wrapping event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_i_grants  <= '0;
      stat_d_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      if (i_done)   stat_i_grants  <= stat_i_grants  + CNT_W'(1);
      if (d_done)   stat_d_grants  <= stat_d_grants  + CNT_W'(1);
      if (conflict) stat_conflicts <= stat_conflicts + CNT_W'(1);
    end
  end
`else
  assign stat_i_grants  = CNT_W'(0);
  assign stat_d_grants  = CNT_W'(0);
  assign stat_conflicts = CNT_W'(0);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: a transaction-level reference model is checked
// against the DUT every cycle, alongside directed scenarios with literal
// expectations.
module tb_wb_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 128;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_cyc, i_stb, i_we, d_cyc, d_stb, d_we;
  logic [AW-1:0] i_adr, d_adr, l2_adr;
  logic [SW-1:0] i_sel, d_sel, l2_sel;
  logic [DW-1:0] i_dat_m, d_dat_m, i_dat_s, d_dat_s, l2_dat_m, l2_dat_s;
  logic          i_ack, d_ack, l2_cyc, l2_stb, l2_we, l2_ack;
  logic [31:0]   stat_i_grants, stat_d_grants, stat_conflicts;

  int n_pass = 0;
  int n_total = 0;
  logic chk_en = 1'b0;
  logic auto_ack = 1'b0;

  wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_sel(i_sel),
    .i_dat_m(i_dat_m), .i_dat_s(i_dat_s), .i_ack(i_ack),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_sel(d_sel),
    .d_dat_m(d_dat_m), .d_dat_s(d_dat_s), .d_ack(d_ack),
    .l2_cyc(l2_cyc), .l2_stb(l2_stb), .l2_we(l2_we), .l2_adr(l2_adr),
    .l2_sel(l2_sel), .l2_dat_m(l2_dat_m), .l2_dat_s(l2_dat_s), .l2_ack(l2_ack),
    .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
    .stat_conflicts(stat_conflicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: who owns the bus (0 none, 1 icache, 2 dcache), who won last.
  int          m_owner = 0;
  int          m_last = 1;
  logic [31:0] m_ig = 0, m_dg = 0, m_cf = 0;
  int          glog[$];

  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      m_owner = 0; m_last = 1; m_ig = 0; m_dg = 0; m_cf = 0;
      glog.delete();
    end else begin
      g = 0;
      if (m_owner == 0) begin
        if (i_cyc && i_stb && d_cyc && d_stb) begin
          m_cf = m_cf + 1;
          g = (m_last == 1) ? 2 : 1;
        end else if (i_cyc && i_stb) g = 1;
        else if (d_cyc && d_stb) g = 2;
        if (g != 0) begin
          m_owner = g; m_last = g; glog.push_back(g);
        end
      end else if (m_owner == 1) begin
        if (!i_cyc) m_owner = 0;
        else if (l2_ack) begin m_ig = m_ig + 1; m_owner = 0; end
      end else begin
        if (!d_cyc) m_owner = 0;
        else if (l2_ack) begin m_dg = m_dg + 1; m_owner = 0; end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic          ec, es, ew;
    logic [AW-1:0] ea;
    logic [SW-1:0] el;
    logic [DW-1:0] ed;
    if (rst_n && chk_en) begin
      ec = 1'b0; es = 1'b0; ew = 1'b0; ea = '0; el = '0; ed = '0;
      if (m_owner == 1) begin
        ec = i_cyc; es = i_stb; ew = i_we; ea = i_adr; el = i_sel; ed = i_dat_m;
      end else if (m_owner == 2) begin
        ec = d_cyc; es = d_stb; ew = d_we; ea = d_adr; el = d_sel; ed = d_dat_m;
      end
      chk("l2_ctl", {l2_cyc, l2_stb, l2_we}, {ec, es, ew});
      chk("l2_adr", l2_adr, ea);
      chk("l2_sel", l2_sel, el);
      chk("l2_dat_m", l2_dat_m, ed);
      chk("acks", {i_ack, d_ack}, {(m_owner == 1) && l2_ack, (m_owner == 2) && l2_ack});
      chk("dat_s", {i_dat_s, d_dat_s}, {l2_dat_s, l2_dat_s});
`ifdef WB_ARBITER_STATS_EN
      chk("stats", {stat_i_grants, stat_d_grants, stat_conflicts}, {m_ig, m_dg, m_cf});
`else
      chk("stats", {stat_i_grants, stat_d_grants, stat_conflicts}, 96'd0);
`endif
    end
  end

  // Simple L2 responder: acks whatever is on the bus while enabled.
  always @(posedge clk) begin
    #2;
    if (auto_ack) l2_ack = l2_cyc && l2_stb;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_cyc = 0; i_stb = 0; i_we = 0; i_adr = '0; i_sel = '0; i_dat_m = '0;
    d_cyc = 0; d_stb = 0; d_we = 0; d_adr = '0; d_sel = '0; d_dat_m = '0;
    l2_ack = 0; l2_dat_s = '0;
  endtask

  task automatic do_reset;
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic exp_stats(input string nm, input logic [31:0] ig, input logic [31:0] dg,
                           input logic [31:0] cf);
`ifdef WB_ARBITER_STATS_EN
    chk(nm, {stat_i_grants, stat_d_grants, stat_conflicts}, {ig, dg, cf});
`else
    chk(nm, {stat_i_grants, stat_d_grants, stat_conflicts}, {ig & 32'd0, dg & 32'd0, cf & 32'd0});
`endif
  endtask

  initial begin
    logic [DW-1:0] a5;
    int            n;
    a5 = {SW{8'hA5}};
    rst_n = 0;
    idle_inputs();
    #12;
    chk("rst_l2", {l2_cyc, l2_stb, l2_we, l2_adr, l2_sel, l2_dat_m}, '0);
    chk("rst_acks", {i_ack, d_ack}, 2'b00);
    exp_stats("rst_stats", 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    chk_en = 1;

    // Single icache read, acked three cycles after the grant edge
    tick();
    i_cyc = 1; i_stb = 1; i_adr = AW'(12'h123); i_sel = '1; i_dat_m = DW'(128'h55);
    tick();
    @(negedge clk);
    chk("rd_l2_stb", {l2_cyc, l2_stb}, 2'b11);
    chk("rd_l2_adr", l2_adr, 12'h123);
    tick(); tick();
    l2_ack = 1; l2_dat_s = a5;
    @(negedge clk);
    chk("rd_i_ack", {i_ack, d_ack}, 2'b10);
    chk("rd_i_dat", i_dat_s, a5);
    tick();
    l2_ack = 0; i_cyc = 0; i_stb = 0;
    @(negedge clk);
    chk("rd_done", {i_ack, l2_cyc}, 2'b00);
    exp_stats("rd_stats", 1, 0, 0);

    // Simultaneous requests straight after reset: dcache first
    do_reset();
    tick();
    i_cyc = 1; i_stb = 1; i_adr = AW'(12'h111);
    d_cyc = 1; d_stb = 1; d_we = 1; d_adr = AW'(12'h222); d_dat_m = DW'(128'hBEEF);
    tick();
    @(negedge clk);
    chk("sim_d_first", {l2_adr, l2_we}, {12'h222, 1'b1});
    tick();
    l2_ack = 1; l2_dat_s = DW'(128'h77);
    @(negedge clk);
    chk("sim_d_ack", {i_ack, d_ack}, 2'b01);
    tick();
    l2_ack = 0; d_cyc = 0; d_stb = 0; d_we = 0;
    @(negedge clk);
    chk("sim_bubble", l2_cyc, 1'b0);
    tick();
    @(negedge clk);
    chk("sim_i_second", {l2_cyc, l2_adr}, {1'b1, 12'h111});
    tick();
    l2_ack = 1;
    @(negedge clk);
    chk("sim_i_ack", {i_ack, d_ack}, 2'b10);
    tick();
    l2_ack = 0; i_cyc = 0; i_stb = 0;
    chk("sim_model_cf", m_cf, 32'd1);
    exp_stats("sim_stats", 1, 1, 1);

    // Sustained contention over eight transfers
    do_reset();
    tick();
    i_cyc = 1; i_stb = 1; i_adr = AW'(12'h0A0);
    d_cyc = 1; d_stb = 1; d_adr = AW'(12'h0D0);
    auto_ack = 1;
    n = 0;
    while ((m_ig + m_dg) < 32'd8 && n < 60) begin
      tick();
      n++;
    end
    chk("cont_timeout", n < 60, 1'b1);
    i_cyc = 0; i_stb = 0; d_cyc = 0; d_stb = 0;
    tick();
    auto_ack = 0; l2_ack = 0;
    chk("cont_len", glog.size(), 8);
    for (int k = 0; k < 8 && k < glog.size(); k++)
      chk($sformatf("cont_order%0d", k), glog[k], (k % 2 == 0) ? 2 : 1);
    chk("cont_model", {m_ig, m_dg}, {32'd4, 32'd4});
    exp_stats("cont_stats", 4, 4, 8);

    // Reset mid-transfer while dcache is granted and L2 is acking
    tick();
    d_cyc = 1; d_stb = 1; d_adr = AW'(12'h3C3);
    tick();
    l2_ack = 1;
    @(negedge clk);
    chk("mid_pre", {l2_cyc, d_ack}, 2'b11);
    tick();
    #1;
    rst_n = 0;
    #1;
    chk("mid_rst_bus", {l2_cyc, l2_adr, d_ack, i_ack}, '0);
    exp_stats("mid_rst_stats", 0, 0, 0);
    d_cyc = 0; d_stb = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("late_ack", {i_ack, d_ack, l2_cyc}, 3'b000);
    tick();
    l2_ack = 0;

    // Abort: icache drops cyc before any ack, then a stray ack arrives
    do_reset();
    tick();
    i_cyc = 1; i_stb = 1; i_adr = AW'(12'h404);
    tick();
    @(negedge clk);
    chk("ab_grant", l2_cyc, 1'b1);
    tick();
    i_cyc = 0; i_stb = 0;
    @(negedge clk);
    chk("ab_drop", l2_cyc, 1'b0);
    tick();
    l2_ack = 1;
    @(negedge clk);
    chk("ab_stray", {i_ack, d_ack}, 2'b00);
    tick();
    l2_ack = 0;
    @(negedge clk);
    chk("ab_idle", l2_cyc, 1'b0);
    exp_stats("ab_stats", 0, 0, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
